// File: rtl/tri_pkg.sv
// Shared types and widths for the point-in-triangle sequencer.
// Build option: TRI_ANY_WINDING_EN accepts both triangle winding orders.
package tri_pkg;

  localparam int TRI_W  = 12;
  localparam int TRI_DW = TRI_W + 1;
  localparam int TRI_PW = 2 * TRI_W + 2;
  localparam int TRI_CW = 2 * TRI_W + 3;

`ifdef TRI_ANY_WINDING_EN
  localparam bit TRI_ANY_WINDING = 1'b1;
`else
  localparam bit TRI_ANY_WINDING = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARESTA0 = 3'd1,
    ARESTA1 = 3'd2,
    ARESTA2 = 3'd3,
    FIM     = 3'd4
  } estado_t;

  // Combine per-edge sign summaries into the inside/boundary verdict.
  function automatic logic tri_dentro(input logic all_ge, input logic all_le);
    return all_ge | (TRI_ANY_WINDING & all_le);
  endfunction

endpackage

// File: rtl/sinal_aresta.sv
// Edge-sign unit: C = (TX-BX)*(AY-BY) - (AX-BX)*(TY-BY), full precision.
module sinal_aresta
  import tri_pkg::*;
#(
  parameter int W = TRI_W
) (
  input  logic [W-1:0] i_ax,
  input  logic [W-1:0] i_ay,
  input  logic [W-1:0] i_bx,
  input  logic [W-1:0] i_by,
  input  logic [W-1:0] i_tx,
  input  logic [W-1:0] i_ty,
  output logic         o_ge0,
  output logic         o_le0
);

  localparam int DW = W + 1;
  localparam int PW = 2 * W + 2;
  localparam int CW = 2 * W + 3;

  logic signed [DW-1:0] w_dtx, w_day, w_dax, w_dty;
  logic signed [PW-1:0] w_p0, w_p1;
  logic signed [CW-1:0] w_c;

  assign w_dtx = $signed({1'b0, i_tx}) - $signed({1'b0, i_bx});
  assign w_day = $signed({1'b0, i_ay}) - $signed({1'b0, i_by});
  assign w_dax = $signed({1'b0, i_ax}) - $signed({1'b0, i_bx});
  assign w_dty = $signed({1'b0, i_ty}) - $signed({1'b0, i_by});

  // Operands widened to the product width so no bit of the product is lost.
  assign w_p0 = $signed({{(PW-DW){w_dtx[DW-1]}}, w_dtx}) * $signed({{(PW-DW){w_day[DW-1]}}, w_day});
  assign w_p1 = $signed({{(PW-DW){w_dax[DW-1]}}, w_dax}) * $signed({{(PW-DW){w_dty[DW-1]}}, w_dty});
  assign w_c  = $signed({w_p0[PW-1], w_p0}) - $signed({w_p1[PW-1], w_p1});

  assign o_ge0 = ~w_c[CW-1];
  assign o_le0 = w_c[CW-1] | (w_c == '0);

endmodule

// File: rtl/triangulo_sequenciador.sv
// Point-in-triangle controller: one shared edge-sign unit stepped over three edges.
// Build option: TRI_ANY_WINDING_EN (see tri_pkg) accepts clockwise triangles too.
module triangulo_sequenciador
  import tri_pkg::*;
#(
  parameter int W = TRI_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         InValid,
  output logic         InReady,
  input  logic [W-1:0] Ponto1X,
  input  logic [W-1:0] Ponto1Y,
  input  logic [W-1:0] Ponto2X,
  input  logic [W-1:0] Ponto2Y,
  input  logic [W-1:0] Ponto3X,
  input  logic [W-1:0] Ponto3Y,
  input  logic [W-1:0] PontoTX,
  input  logic [W-1:0] PontoTY,
  output logic         OutValid,
  input  logic         OutReady,
  output logic         Dentro,
  output logic         Ocupado
);

  estado_t r_state, w_state_n;

  logic [W-1:0] r_p1x, r_p1y, r_p2x, r_p2y, r_p3x, r_p3y, r_tx, r_ty;
  logic [W-1:0] w_ax, w_ay, w_bx, w_by;
  logic [2:0]   r_ge, r_le;
  logic         r_dentro;
  logic         w_ge, w_le;

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      IDLE:    if (InValid) w_state_n = ARESTA0;
      ARESTA0: w_state_n = ARESTA1;
      ARESTA1: w_state_n = ARESTA2;
      ARESTA2: w_state_n = FIM;
      FIM:     if (OutReady) w_state_n = IDLE;
      default: w_state_n = IDLE;
    endcase
  end

  // Operand mux feeding the single edge unit: edge k runs in ARESTAk.
  always_comb begin
    w_ax = r_p3x; w_ay = r_p3y; w_bx = r_p1x; w_by = r_p1y;
    case (r_state)
      ARESTA0: begin w_ax = r_p1x; w_ay = r_p1y; w_bx = r_p2x; w_by = r_p2y; end
      ARESTA1: begin w_ax = r_p2x; w_ay = r_p2y; w_bx = r_p3x; w_by = r_p3y; end
      default: ;
    endcase
  end

  sinal_aresta #(.W(W)) u_aresta (
    .i_ax (w_ax),
    .i_ay (w_ay),
    .i_bx (w_bx),
    .i_by (w_by),
    .i_tx (r_tx),
    .i_ty (r_ty),
    .o_ge0(w_ge),
    .o_le0(w_le)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_ge     <= '0;
      r_le     <= '0;
      r_dentro <= 1'b0;
    end else begin
      r_state <= w_state_n;
      case (r_state)
        IDLE: if (InValid) begin
          r_p1x <= Ponto1X; r_p1y <= Ponto1Y;
          r_p2x <= Ponto2X; r_p2y <= Ponto2Y;
          r_p3x <= Ponto3X; r_p3y <= Ponto3Y;
          r_tx  <= PontoTX; r_ty  <= PontoTY;
          r_dentro <= 1'b0;
        end
        ARESTA0: begin r_ge[0] <= w_ge; r_le[0] <= w_le; end
        ARESTA1: begin r_ge[1] <= w_ge; r_le[1] <= w_le; end
        ARESTA2: begin
          r_ge[2]  <= w_ge;
          r_le[2]  <= w_le;
          // Verdict formed as the last edge lands so Dentro is ready on FIM entry.
          r_dentro <= tri_dentro(r_ge[0] & r_ge[1] & w_ge, r_le[0] & r_le[1] & w_le);
        end
        default: ;
      endcase
    end
  end

  assign InReady  = (r_state == IDLE);
  assign OutValid = (r_state == FIM);
  assign Ocupado  = (r_state != IDLE);
  assign Dentro   = r_dentro;

endmodule

// File: tb/tb_triangulo_sequenciador.sv
// Randomized and directed bench for triangulo_sequenciador against an arithmetic model.
module tb_triangulo_sequenciador;
  localparam int W = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic InValid = 1'b0;
  logic OutReady = 1'b0;
  logic [W-1:0] p1x = '0, p1y = '0, p2x = '0, p2y = '0, p3x = '0, p3y = '0, ptx = '0, pty = '0;
  logic InReady, OutValid, Dentro, Ocupado;

  int n_vec = 0;
  int n_err = 0;

  triangulo_sequenciador #(.W(W)) dut (
    .clk(clk), .rst(rst),
    .InValid(InValid), .InReady(InReady),
    .Ponto1X(p1x), .Ponto1Y(p1y),
    .Ponto2X(p2x), .Ponto2Y(p2y),
    .Ponto3X(p3x), .Ponto3Y(p3y),
    .PontoTX(ptx), .PontoTY(pty),
    .OutValid(OutValid), .OutReady(OutReady),
    .Dentro(Dentro), .Ocupado(Ocupado)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic longint aresta(input longint ax, ay, bx, by, tx, ty);
    return (tx - bx) * (ay - by) - (ax - bx) * (ty - by);
  endfunction

  function automatic bit modelo(input int ax, ay, bx, by, cx, cy, tx, ty);
    longint c[3];
    bit ge, le;
    c[0] = aresta(ax, ay, bx, by, tx, ty);
    c[1] = aresta(bx, by, cx, cy, tx, ty);
    c[2] = aresta(cx, cy, ax, ay, tx, ty);
    ge = (c[0] >= 0) && (c[1] >= 0) && (c[2] >= 0);
    le = (c[0] <= 0) && (c[1] <= 0) && (c[2] <= 0);
`ifdef TRI_ANY_WINDING_EN
    return ge | le;
`else
    return ge;
`endif
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int ax, ay, bx, by, cx, cy, tx, ty);
    p1x = W'(ax); p1y = W'(ay); p2x = W'(bx); p2y = W'(by);
    p3x = W'(cx); p3y = W'(cy); ptx = W'(tx); pty = W'(ty);
  endtask

  task automatic scramble;
    drive($urandom_range(0, 4095), $urandom_range(0, 4095), $urandom_range(0, 4095),
          $urandom_range(0, 4095), $urandom_range(0, 4095), $urandom_range(0, 4095),
          $urandom_range(0, 4095), $urandom_range(0, 4095));
  endtask

  task automatic run_job(input int ax, ay, bx, by, cx, cy, tx, ty, input int hold, input bit expd);
    int lat;
    chk("in_ready_idle", InReady, 1);
    drive(ax, ay, bx, by, cx, cy, tx, ty);
    InValid = 1'b1;
    OutReady = (hold == 0);
    tick;
    InValid = 1'b0;
    scramble;
    chk("ocupado_busy", Ocupado, 1);
    chk("in_ready_busy", InReady, 0);
    lat = 0;
    while (!OutValid && lat < 20) begin
      tick;
      lat++;
    end
    chk("latencia", lat, 3);
    chk("dentro", Dentro, expd);
    for (int i = 0; i < hold; i++) begin
      if (i == 2) begin
        drive(tx, ty, cx, cy, bx, by, ax, ay);
        InValid = 1'b1;
      end else begin
        InValid = 1'b0;
      end
      tick;
      chk("hold_valid", OutValid, 1);
      chk("hold_dentro", Dentro, expd);
      chk("hold_in_ready", InReady, 0);
    end
    InValid = 1'b0;
    OutReady = 1'b1;
    tick;
    chk("out_drop", OutValid, 0);
    chk("idle_in_ready", InReady, 1);
    chk("idle_ocupado", Ocupado, 0);
    OutReady = 1'b0;
  endtask

  initial begin
    bit exp_cw;
    rst = 1'b1;
    repeat (3) tick;
    rst = 1'b0;
    chk("rst_in_ready", InReady, 1);
    chk("rst_out_valid", OutValid, 0);
    chk("rst_dentro", Dentro, 0);
    chk("rst_ocupado", Ocupado, 0);

    run_job(10, 10, 30, 10, 20, 30, 15, 15, 0, 1'b1);
    run_job(10, 10, 30, 10, 20, 30, 9, 15, 1, 1'b0);
    run_job(10, 10, 30, 10, 20, 30, 20, 10, 0, 1'b1);
`ifdef TRI_ANY_WINDING_EN
    exp_cw = 1'b1;
`else
    exp_cw = 1'b0;
`endif
    run_job(10, 10, 20, 30, 30, 10, 15, 15, 0, exp_cw);
    run_job(10, 10, 30, 10, 20, 30, 15, 15, 6, 1'b1);

    // Reset landing in the second edge cycle discards the job.
    drive(10, 10, 30, 10, 20, 30, 15, 15);
    InValid = 1'b1;
    tick;
    InValid = 1'b0;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("midrst_in_ready", InReady, 1);
    chk("midrst_out_valid", OutValid, 0);
    chk("midrst_ocupado", Ocupado, 0);
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("midrst_no_valid", OutValid, 0);
    end
    run_job(10, 10, 30, 10, 20, 30, 9, 15, 0, 1'b0);

    run_job(0, 0, 4095, 0, 0, 4095, 4095, 4095, 0, 1'b0);
    run_job(0, 0, 4095, 0, 0, 4095, 1, 1, 2, 1'b1);

    for (int j = 0; j < 60; j++) begin
      int c[8];
      int hi;
      hi = (j % 2 == 0) ? 40 : 4095;
      for (int k = 0; k < 8; k++) c[k] = $urandom_range(0, hi);
      run_job(c[0], c[1], c[2], c[3], c[4], c[5], c[6], c[7], $urandom_range(0, 3),
              modelo(c[0], c[1], c[2], c[3], c[4], c[5], c[6], c[7]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
